// File: rtl/up_mixer_pipe.sv
`default_nettype none
// ============================================================================
// Module      : up_mixer_pipe
// Description : Transmit-side complex up-converter (baseband x LO, no conjugate)
//               3-stage valid/ready pipeline with flush and saturation counter.
// Revision    : 1.0 - initial release
// ============================================================================
module up_mixer_pipe #(
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 16,
    parameter int SATCNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [INPUT_WIDTH-1:0]  bb_i,
    input  logic signed [INPUT_WIDTH-1:0]  bb_q,
    input  logic signed [INPUT_WIDTH-1:0]  lo_i,
    input  logic signed [INPUT_WIDTH-1:0]  lo_q,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [OUTPUT_WIDTH-1:0] i_out,
    output logic signed [OUTPUT_WIDTH-1:0] q_out,
    output logic                           sat_flag,
    output logic [SATCNT_WIDTH-1:0]        sat_count,
    input  logic                           sat_clr
);

    localparam int C_PROD_W = 2 * INPUT_WIDTH;
    localparam int C_SUM_W  = 2 * INPUT_WIDTH + 1;
    localparam int C_SHIFT  = 2 * INPUT_WIDTH - 1 - OUTPUT_WIDTH;

    localparam logic signed [C_SUM_W-1:0] C_MAX =
        $signed({{(C_SUM_W - OUTPUT_WIDTH + 1){1'b0}}, {(OUTPUT_WIDTH - 1){1'b1}}});
    localparam logic signed [C_SUM_W-1:0] C_MIN =
        $signed({{(C_SUM_W - OUTPUT_WIDTH + 1){1'b1}}, {(OUTPUT_WIDTH - 1){1'b0}}});

    // Stage 1 registers
    logic signed [INPUT_WIDTH-1:0] bb_i_q, bb_q_q, lo_i_q, lo_q_q;
    logic                          v1_q;
    // Stage 2 registers
    logic signed [C_PROD_W-1:0]    pii_q, pqq_q, piq_q, pqi_q;
    logic signed [C_PROD_W-1:0]    pii_d, pqq_d, piq_d, pqi_d;
    logic                          v2_q;
    // Stage 3 registers
    logic signed [OUTPUT_WIDTH-1:0] i_out_q, q_out_q, i_out_d, q_out_d;
    logic                           sat_flag_q, sat_flag_d;
    logic                           out_valid_q;
    logic [SATCNT_WIDTH-1:0]        sat_count_q, sat_count_d;

    logic                        w_advance;
    logic signed [C_SUM_W-1:0]   w_sum_i, w_sum_q, w_shr_i, w_shr_q;
    logic                        w_clip_i, w_clip_q;

    assign w_advance = ~out_valid_q | out_ready;
    // Held low during reset so nothing is accepted before the pipe is live.
    assign in_ready  = w_advance & ~flush & rst_n;

    assign pii_d = C_PROD_W'(bb_i_q) * C_PROD_W'(lo_i_q);
    assign pqq_d = C_PROD_W'(bb_q_q) * C_PROD_W'(lo_q_q);
    assign piq_d = C_PROD_W'(bb_i_q) * C_PROD_W'(lo_q_q);
    assign pqi_d = C_PROD_W'(bb_q_q) * C_PROD_W'(lo_i_q);

    always_comb begin
        w_sum_i    = C_SUM_W'(pii_q) - C_SUM_W'(pqq_q);
        w_sum_q    = C_SUM_W'(piq_q) + C_SUM_W'(pqi_q);
        // Arithmetic shift floors toward -inf; no rounding is intended.
        w_shr_i    = w_sum_i >>> C_SHIFT;
        w_shr_q    = w_sum_q >>> C_SHIFT;
        w_clip_i   = 1'b0;
        w_clip_q   = 1'b0;
        i_out_d    = w_shr_i[OUTPUT_WIDTH-1:0];
        q_out_d    = w_shr_q[OUTPUT_WIDTH-1:0];
        if (w_shr_i > C_MAX) begin
            i_out_d  = C_MAX[OUTPUT_WIDTH-1:0];
            w_clip_i = 1'b1;
        end else if (w_shr_i < C_MIN) begin
            i_out_d  = C_MIN[OUTPUT_WIDTH-1:0];
            w_clip_i = 1'b1;
        end
        if (w_shr_q > C_MAX) begin
            q_out_d  = C_MAX[OUTPUT_WIDTH-1:0];
            w_clip_q = 1'b1;
        end else if (w_shr_q < C_MIN) begin
            q_out_d  = C_MIN[OUTPUT_WIDTH-1:0];
            w_clip_q = 1'b1;
        end
        sat_flag_d = w_clip_i | w_clip_q;
    end

    always_comb begin
        sat_count_d = sat_count_q;
        if (sat_clr) begin
            sat_count_d = '0;
        end else if (out_valid_q && out_ready && sat_flag_q && !(&sat_count_q)) begin
            sat_count_d = sat_count_q + SATCNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bb_i_q      <= '0;
            bb_q_q      <= '0;
            lo_i_q      <= '0;
            lo_q_q      <= '0;
            v1_q        <= 1'b0;
            pii_q       <= '0;
            pqq_q       <= '0;
            piq_q       <= '0;
            pqi_q       <= '0;
            v2_q        <= 1'b0;
            i_out_q     <= '0;
            q_out_q     <= '0;
            sat_flag_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
            if (w_advance) begin
                bb_i_q     <= bb_i;
                bb_q_q     <= bb_q;
                lo_i_q     <= lo_i;
                lo_q_q     <= lo_q;
                pii_q      <= pii_d;
                pqq_q      <= pqq_d;
                piq_q      <= piq_d;
                pqi_q      <= pqi_d;
                i_out_q    <= i_out_d;
                q_out_q    <= q_out_d;
                sat_flag_q <= sat_flag_d;
            end
            // Flush overrides advance; only the valids matter, data is left as-is.
            if (flush) begin
                v1_q        <= 1'b0;
                v2_q        <= 1'b0;
                out_valid_q <= 1'b0;
            end else if (w_advance) begin
                v1_q        <= in_valid & in_ready;
                v2_q        <= v1_q;
                out_valid_q <= v2_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign i_out     = i_out_q;
    assign q_out     = q_out_q;
    assign sat_flag  = sat_flag_q;
    assign sat_count = sat_count_q;

endmodule
`default_nettype wire

// File: tb/tb_up_mixer_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_up_mixer_pipe
// Description : Self-checking bench for up_mixer_pipe with a math-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_up_mixer_pipe;

    localparam int W  = 16;
    localparam int OW = 16;
    localparam int SH = 2 * W - 1 - OW;

    logic                  clk = 1'b0;
    logic                  rst_n, flush, in_valid, out_ready, sat_clr;
    logic                  in_ready, out_valid, sat_flag;
    logic signed [W-1:0]   bb_i, bb_q, lo_i, lo_q;
    logic signed [OW-1:0]  i_out, q_out;
    logic [15:0]           sat_count;

    int n_cmp;
    int n_fail;
    int exp_sat;

    typedef struct {
        int i;
        int q;
        bit s;
    } exp_t;

    always #5 clk = ~clk;

    up_mixer_pipe #(.INPUT_WIDTH(W), .OUTPUT_WIDTH(OW), .SATCNT_WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bb_i     (bb_i),
        .bb_q     (bb_q),
        .lo_i     (lo_i),
        .lo_q     (lo_q),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .i_out    (i_out),
        .q_out    (q_out),
        .sat_flag (sat_flag),
        .sat_count(sat_count),
        .sat_clr  (sat_clr)
    );

    // Complex product, floor-scaled and clamped to the output range.
    function automatic void refmix(input int bi, input int bq, input int li, input int lq,
                                   output exp_t e);
        longint si, sq, mx, mn;
        mx = (longint'(1) <<< (OW - 1)) - 1;
        mn = -(longint'(1) <<< (OW - 1));
        si = (longint'(bi) * li - longint'(bq) * lq) >>> SH;
        sq = (longint'(bi) * lq + longint'(bq) * li) >>> SH;
        e.s = (si > mx) || (si < mn) || (sq > mx) || (sq < mn);
        e.i = int'((si > mx) ? mx : (si < mn) ? mn : si);
        e.q = int'((sq > mx) ? mx : (sq < mn) ? mn : sq);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_clip_sample();
        bb_i = -16'sd32768;
        bb_q = -16'sd32768;
        lo_i = -16'sd32768;
        lo_q = 16'sd32767;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || sat_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: out_valid=%b in_ready=%b sat_flag=%b want 0 0 0", out_valid, in_ready, sat_flag);
        end
        n_cmp++;
        if (i_out !== 16'sd0 || q_out !== 16'sd0 || sat_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_data: i=%0d q=%0d cnt=%0d want 0 0 0", i_out, q_out, sat_count);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        tick();
    endtask

    task automatic test_directed();
        int vbi[5] = '{16384, 16384, 0, -1, 1};
        int vbq[5] = '{0, 0, 16384, 0, 0};
        int vli[5] = '{16384, 0, 0, 1, 1};
        int vlq[5] = '{0, 16384, 16384, 0, 0};
        int ei[5]  = '{8192, 0, -8192, -1, 0};
        int eq[5]  = '{0, 8192, 0, 0, 0};
        out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            in_valid = (c < 5);
            if (c < 5) begin
                bb_i = 16'(vbi[c]);
                bb_q = 16'(vbq[c]);
                lo_i = 16'(vli[c]);
                lo_q = 16'(vlq[c]);
            end
            #1;
            if (c < 5) begin
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL dir_in_ready c=%0d: got %b want 1", c, in_ready);
                end
            end
            if (c >= 3 && c < 8) begin
                n_cmp++;
                if (out_valid !== 1'b1 || i_out !== ei[c-3] || q_out !== eq[c-3] || sat_flag !== 1'b0) begin
                    n_fail++;
                    $display("FAIL dir_out c=%0d: v=%b i=%0d q=%0d s=%b want 1 %0d %0d 0",
                             c, out_valid, i_out, q_out, sat_flag, ei[c-3], eq[c-3]);
                end
            end else begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL dir_latency c=%0d: out_valid=%b want 0", c, out_valid);
                end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_saturation();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sat_clr   = 1'b1;
        tick();
        sat_clr = 1'b0;
        #1;
        n_cmp++;
        if (sat_count !== 16'd0) begin
            n_fail++;
            $display("FAIL sat_clr_idle: got %0d want 0", sat_count);
        end
        set_clip_sample();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || i_out !== 16'sd32767 || q_out !== 16'sd1 || sat_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_out: v=%b i=%0d q=%0d s=%b want 1 32767 1 1", out_valid, i_out, q_out, sat_flag);
        end
        n_cmp++;
        if (sat_count !== 16'd0) begin
            n_fail++;
            $display("FAIL sat_cnt_pre: got %0d want 0", sat_count);
        end
        tick();
        #1;
        n_cmp++;
        if (sat_count !== 16'd1) begin
            n_fail++;
            $display("FAIL sat_cnt_inc: got %0d want 1", sat_count);
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        sat_clr = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || sat_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_second: v=%b s=%b want 1 1", out_valid, sat_flag);
        end
        tick();
        sat_clr = 1'b0;
        #1;
        n_cmp++;
        if (sat_count !== 16'd0) begin
            n_fail++;
            $display("FAIL sat_clr_wins: got %0d want 0", sat_count);
        end
        exp_sat = 0;
        tick();
    endtask

    task automatic test_backpressure();
        exp_t        exp_q[$];
        exp_t        e;
        exp_t        got_e;
        int          sent;
        int          got;
        bit          have_prev;
        logic [33:0] prev;
        sent      = 0;
        got       = 0;
        have_prev = 1'b0;
        prev      = '0;
        for (int cyc = 0; cyc < 2000 && got < 20; cyc++) begin
            in_valid  = (sent < 20) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            bb_i = 16'($urandom);
            bb_q = 16'($urandom);
            lo_i = 16'($urandom);
            lo_q = 16'($urandom);
            #1;
            if (have_prev) begin
                n_cmp++;
                if ({out_valid, i_out, q_out, sat_flag} !== prev) begin
                    n_fail++;
                    $display("FAIL bp_stable cyc=%0d: got %h want %h", cyc, {out_valid, i_out, q_out, sat_flag}, prev);
                end
            end
            if (out_valid && !out_ready) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_in_ready cyc=%0d: got %b want 0", cyc, in_ready);
                end
            end
            if (in_valid && in_ready) begin
                refmix(int'(bb_i), int'(bb_q), int'(lo_i), int'(lo_q), e);
                exp_q.push_back(e);
                sent++;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_extra cyc=%0d: output with %0d pending, want none", cyc, exp_q.size());
                end else begin
                    got_e = exp_q.pop_front();
                    if (i_out !== got_e.i || q_out !== got_e.q || sat_flag !== got_e.s) begin
                        n_fail++;
                        $display("FAIL bp_data #%0d: i=%0d q=%0d s=%b want %0d %0d %b",
                                 got, i_out, q_out, sat_flag, got_e.i, got_e.q, got_e.s);
                    end
                    if (got_e.s && exp_sat < 65535) exp_sat++;
                end
                got++;
            end
            have_prev = out_valid && !out_ready;
            prev      = {out_valid, i_out, q_out, sat_flag};
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (got !== 20 || sent !== 20) begin
            n_fail++;
            $display("FAIL bp_count: sent=%0d got=%0d want 20 20", sent, got);
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_drain k=%0d: out_valid=%b want 0", k, out_valid);
            end
            tick();
        end
        n_cmp++;
        if (sat_count !== 16'(exp_sat)) begin
            n_fail++;
            $display("FAIL bp_satcnt: got %0d want %0d", sat_count, exp_sat);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            bb_i = 16'(1000 * (c + 1));
            bb_q = 16'sd0;
            lo_i = 16'sd16384;
            lo_q = 16'sd0;
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fl_fill c=%0d: in_ready=%b want 1", c, in_ready);
            end
            tick();
        end
        flush = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL fl_during: in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
        end
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL fl_gone k=%0d: out_valid=%b want 0", k, out_valid);
            end
            tick();
        end
        n_cmp++;
        if (sat_count !== 16'(exp_sat)) begin
            n_fail++;
            $display("FAIL fl_satcnt: got %0d want %0d", sat_count, exp_sat);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        set_clip_sample();
        for (int c = 0; c < 5; c++) begin
            in_valid = (c < 4);
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || sat_count !== 16'(exp_sat + 2)) begin
            n_fail++;
            $display("FAIL rm_pre: v=%b cnt=%0d want 1 %0d", out_valid, sat_count, exp_sat + 2);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || sat_count !== 16'd0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_async: v=%b cnt=%0d rdy=%b want 0 0 0", out_valid, sat_count, in_ready);
        end
        exp_sat = 0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rm_after k=%0d: out_valid=%b want 0", k, out_valid);
            end
            tick();
        end
    endtask

    task automatic test_sat_hold();
        sat_clr   = 1'b1;
        out_ready = 1'b1;
        tick();
        sat_clr = 1'b0;
        set_clip_sample();
        in_valid = 1'b1;
        for (int k = 0; k < 65537; k++) tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        #1;
        n_cmp++;
        if (sat_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_hold: got %0d want 65535", sat_count);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        exp_sat   = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sat_clr   = 1'b0;
        bb_i      = '0;
        bb_q      = '0;
        lo_i      = '0;
        lo_q      = '0;
        test_reset();
        test_directed();
        test_saturation();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_sat_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
